wm_panel_input: RTL
===================

WM_PANEL_INPUT -- requirements
Module: wm_panel_input

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 160000, meaning the number of consecutive stable cycles needed before a debounced level changes (10 ms at 16 MHz).
REQ-002 SHALL provide parameter DB_WIDTH, default 18, meaning the debounce counter width; it must satisfy 2^DB_WIDTH > DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk, input, 1: single system clock; all state is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert and active-low.
REQ-005 SHALL have port sw_raw, input, 7: asynchronous panel switches; [1:0] load, [3:2] temp, [4] rinse2, [5] spin2, [6] lid (1=open).
REQ-006 SHALL have port start_btn_raw, input, 1: asynchronous start button, active-high, bouncy.
REQ-007 SHALL have port busy, input, 1: high while the downstream controller is not in OFF.
REQ-008 SHALL have port start_pulse, output, 1: one-cycle start request to the controller.
REQ-009 SHALL have port cfg_load, output, 2: the load code, either tracking or frozen.
REQ-010 SHALL have port cfg_temp, output, 2: the temp code, either tracking or frozen.
REQ-011 SHALL have port cfg_rinse2, output, 1: the rinse2 option, either tracking or frozen.
REQ-012 SHALL have port cfg_spin2, output, 1: the spin2 option, either tracking or frozen.
REQ-013 SHALL have port lid_closed, output, 1: debounced lid state, 1=closed.
REQ-014 SHALL have port cfg_error, output, 1: high when cfg_load==2'b11 or cfg_temp==2'b11.
REQ-015 SHALL have port lid_abort, output, 1: one-cycle pulse when the lid opens while busy.

Function
REQ-016 SHALL pass every raw input through a 2-flop synchronizer before any other use.
REQ-017 SHALL debounce start and lid: the counter clears whenever sync==debounced; otherwise it increments, and on reaching DEBOUNCE_CYCLES-1 the debounced level takes sync and the counter clears.
REQ-018 SHALL assert start_pulse for exactly one cycle, registered, in the cycle after the debounced start rises, but only if busy==0, lid_closed==1 and cfg_error==0 in the rise cycle.
REQ-019 SHALL make start_pulse first high 3+DEBOUNCE_CYCLES cycles after a clean raw rising edge.
REQ-020 SHALL be edge-qualified: a button held high produces no further pulse (including after busy falls or the lid closes), and a new debounced rise is required.
REQ-021 SHALL ignore a debounced start rise that fails any qualifier in REQ-018; it SHALL NOT be queued.
REQ-022 SHALL make the cfg_* outputs track the synchronized switches one cycle later while idle, where idle means busy==0 and no start_pulse this cycle.
REQ-023 SHALL capture cfg_* in the start_pulse cycle and hold it until busy falls; switch changes while frozen SHALL be ignored.
REQ-024 SHALL handle busy falling in a cycle with a switch change by resuming tracking the next cycle and showing the new value one cycle later.
REQ-025 SHALL compute cfg_error combinationally from the registered cfg_* outputs.
REQ-026 SHALL pulse lid_abort for one cycle on a debounced lid 0->1 transition while busy==1, and SHALL NOT pulse it while idle.
REQ-027 SHALL produce no glitch on a bounce shorter than DEBOUNCE_CYCLES; a partial count is discarded when the input returns.

Reset
REQ-028 SHALL, on rst_n low, immediately clear the synchronizers, counters, start_pulse, lid_abort and all cfg_*.
REQ-029 SHALL reset the debounced lid to open, so lid_closed==0, and the debounced start to 0.
REQ-030 SHALL, after reset releases with the button already held, issue no start_pulse until a release and a new press.

Structure
REQ-031 SHALL take the load/temp encodings, controller state codes and dwell constants from shared package wm_pkg.
REQ-032 SHALL implement debounce in sub-module wm_debounce (parameters DEBOUNCE_CYCLES and DB_WIDTH; ports clk, rst_n, din, dout, rise, fall, reset value as a parameter), instantiated for start and for lid.

Verification
REQ-033 SHALL cover clean press with DEBOUNCE_CYCLES=4, lid closed, sw=00/00, busy=0 -> start_pulse high 1 cycle, 7 cycles after the raw edge, cfg captured.
REQ-034 SHALL cover a bounce 1,0,1,0 every 2 cycles then stable high -> exactly one start_pulse, 7 cycles after the last raw edge.
REQ-035 SHALL cover load=11 (or temp=11), press -> cfg_error=1, no start_pulse; fix switches while holding -> still no pulse.
REQ-036 SHALL cover switch changes while busy=1 -> cfg_* stay frozen; busy falls -> new values two cycles after the fall.
REQ-037 SHALL cover lid raw 0->1 held while busy=1 -> lid_abort one cycle, lid_closed=0; the same while busy=0 -> no lid_abort.
REQ-038 SHALL cover rst_n low mid-debounce with the button held -> outputs 0, lid_closed=0; after release, no pulse until re-press.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: panel encodings, controller state codes, dwell times.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wm_pkg;

   // Load-size switch code; 2'b11 is not a legal selection.
   typedef enum logic [1:0] {
      LOAD_SMALL   = 2'b00,
      LOAD_MEDIUM  = 2'b01,
      LOAD_LARGE   = 2'b10,
      LOAD_INVALID = 2'b11
   } load_e;

   // Water temperature switch code; 2'b11 is not a legal selection.
   typedef enum logic [1:0] {
      TEMP_COLD    = 2'b00,
      TEMP_WARM    = 2'b01,
      TEMP_HOT     = 2'b10,
      TEMP_INVALID = 2'b11
   } temp_e;

   // Downstream controller state codes (busy is high in anything but ST_OFF).
   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_FILL  = 3'd1,
      ST_WASH  = 3'd2,
      ST_RINSE = 3'd3,
      ST_SPIN  = 3'd4,
      ST_DRAIN = 3'd5
   } ctrl_state_e;

   // Controller dwell times in seconds.
   localparam int unsigned WASH_DWELL_S  = 600;
   localparam int unsigned RINSE_DWELL_S = 300;
   localparam int unsigned SPIN_DWELL_S  = 240;

   // Raw panel switch bundle, bit-for-bit the sw_raw port layout.
   typedef struct packed {
      logic  lid;      // [6] 1 = open
      logic  spin2;    // [5]
      logic  rinse2;   // [4]
      temp_e temp;     // [3:2]
      load_e load;     // [1:0]
   } panel_sw_t;

   // Wash configuration presented to the controller.
   typedef struct packed {
      load_e load;
      temp_e temp;
      logic  rinse2;
      logic  spin2;
   } panel_cfg_t;

   function automatic logic cfg_invalid(input panel_cfg_t c);
      return (c.load == LOAD_INVALID) || (c.temp == TEMP_INVALID);
   endfunction

endpackage

// File: rtl/wm_debounce.sv
// Level debouncer: output follows din only after DEBOUNCE_CYCLES consecutive disagreeing samples.
// Latency: DEBOUNCE_CYCLES cycles from a stable din change to dout/rise/fall (all registered).
// Backpressure: none; din is sampled every cycle.
// Ports: clk, rst_n (async, active-low), din (already synchronized), dout (debounced level),
//        rise/fall (one-cycle pulses in the cycle dout has just changed).
module wm_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 160000,
   parameter int unsigned DB_WIDTH        = 18,
   parameter logic        RST_VAL         = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [DB_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         dout  <= RST_VAL;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (din == dout) begin
            // Any return to the current level throws away a partial count.
            cnt_q <= '0;
         end else if (cnt_q == DB_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
            dout  <= din;
            cnt_q <= '0;
            rise  <= din;
            fall  <= ~din;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/wm_panel_input.sv
// Front-panel conditioning: synchronize/debounce switches and buttons, qualify start, freeze config.
// Latency: start_pulse 3+DEBOUNCE_CYCLES cycles after a clean press; cfg_* one cycle after sync.
// Backpressure: none; an unqualified start press is dropped, never queued.
// Ports: clk, rst_n; sw_raw[6:0] {lid,spin2,rinse2,temp,load}, start_btn_raw, busy (controller not OFF);
//        start_pulse, cfg_load/temp/rinse2/spin2, lid_closed, cfg_error, lid_abort.
module wm_panel_input
   import wm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 160000,
   parameter int unsigned DB_WIDTH        = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] sw_raw,
   input  logic       start_btn_raw,
   input  logic       busy,
   output logic       start_pulse,
   output logic [1:0] cfg_load,
   output logic [1:0] cfg_temp,
   output logic       cfg_rinse2,
   output logic       cfg_spin2,
   output logic       lid_closed,
   output logic       cfg_error,
   output logic       lid_abort
);

   // Two-flop synchronizer for every raw input: {start, sw[6:0]}.
   logic [7:0] sync_q1, sync_q2;
   panel_sw_t  sw_s;
   logic       start_s;

   // Synchronizer warm-up count; sync_q2 only reflects the pins after two edges.
   logic [1:0] prime_q;
   // Set once the button has been seen released, so a press held through reset is ignored.
   logic       armed_q;
   // Holds cfg from the start_pulse cycle until busy is observed low.
   logic       frozen_q;

   logic start_db, start_rise, start_fall;
   logic lid_open_db, lid_rise, lid_fall;

   panel_cfg_t cfg_q;

   assign sw_s    = panel_sw_t'(sync_q2[6:0]);
   assign start_s = sync_q2[7];

   wm_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_WIDTH        (DB_WIDTH),
      .RST_VAL         (1'b0)
   ) u_start_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (start_s),
      .dout  (start_db),
      .rise  (start_rise),
      .fall  (start_fall)
   );

   // Lid comes out of reset as open so nothing starts until it is seen closed.
   wm_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_WIDTH        (DB_WIDTH),
      .RST_VAL         (1'b1)
   ) u_lid_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sw_s.lid),
      .dout  (lid_open_db),
      .rise  (lid_rise),
      .fall  (lid_fall)
   );

   logic unused_ok;
   assign unused_ok = &{1'b0, start_db, start_fall, lid_fall};

   assign lid_closed = ~lid_open_db;
   assign cfg_error  = cfg_invalid(cfg_q);
   assign cfg_load   = cfg_q.load;
   assign cfg_temp   = cfg_q.temp;
   assign cfg_rinse2 = cfg_q.rinse2;
   assign cfg_spin2  = cfg_q.spin2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1     <= '0;
         sync_q2     <= '0;
         prime_q     <= '0;
         armed_q     <= 1'b0;
         frozen_q    <= 1'b0;
         start_pulse <= 1'b0;
         lid_abort   <= 1'b0;
         cfg_q       <= '0;
      end else begin
         sync_q1 <= {start_btn_raw, sw_raw};
         sync_q2 <= sync_q1;

         if (prime_q != 2'd2) begin
            prime_q <= prime_q + 2'd1;
         end
         if ((prime_q == 2'd2) && !start_s) begin
            armed_q <= 1'b1;
         end

         // Qualifiers are sampled in the cycle the debounced rise is visible.
         start_pulse <= start_rise & armed_q & ~busy & lid_closed & ~cfg_error;
         lid_abort   <= lid_rise & busy;

         if (!busy && !start_pulse && !frozen_q) begin
            cfg_q <= '{load: sw_s.load, temp: sw_s.temp, rinse2: sw_s.rinse2, spin2: sw_s.spin2};
         end

         // Release is one cycle after busy is seen low, so tracking resumes the cycle after the fall.
         if (start_pulse) begin
            frozen_q <= 1'b1;
         end else if (!busy) begin
            frozen_q <= 1'b0;
         end
      end
   end

endmodule
